uart_tx_fifo: RTL

//  Buffered, parametrised UART transmitter for the CPU's memory-mapped UART store path.

---
 rtl/uart_tx_fifo.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter for the CPU MMIO store path.
// Stores push characters into a circular FIFO; a four-state FSM drains it as LSB-first frames.
module uart_tx_fifo #(
  parameter int BAUD_DIV   = 1085,
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [DATA_BITS-1:0]        wr_data,
  input  logic                        clr_ovf,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        busy,
  output logic                        overflow,
  output logic                        uart_tx
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int BCW = $clog2(STOP_BITS * BAUD_DIV);
  localparam int BTW = $clog2(DATA_BITS);
  localparam logic [BCW-1:0] BIT_LAST  = BCW'(BAUD_DIV - 1);
  localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS * BAUD_DIV - 1);
  localparam logic [BTW-1:0] DATA_LAST = BTW'(DATA_BITS - 1);
  localparam logic [LW-1:0]  DEPTH_L   = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]        wptr_r;
  logic [AW-1:0]        rptr_r;
  logic [LW-1:0]        level_r;
  logic [LW-1:0]        level_s;
  logic                 full_r;
  logic                 empty_r;
  logic                 ovf_r;
  logic                 busy_r;
  logic                 tx_r;
  logic                 push_s;
  logic                 pop_s;
  logic                 tx_s;
  state_t               state_r;
  state_t               state_s;
  logic [BCW-1:0]       bcnt_r;
  logic [BCW-1:0]       bcnt_s;
  logic [BTW-1:0]       bitcnt_r;
  logic [BTW-1:0]       bitcnt_s;
  logic [DATA_BITS-1:0] shreg_r;
  logic [DATA_BITS-1:0] shreg_s;

  // full is the registered flag, so a push in the same cycle as a pop from a full FIFO is dropped
  assign push_s  = wr_en & ~full_r;
  assign level_s = level_r + LW'(push_s) - LW'(pop_s);

  // FIFO storage write port
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wptr_r] <= wr_data;
    end
  end

  // FIFO pointers, occupancy flags and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r  <= {AW{1'b0}};
      rptr_r  <= {AW{1'b0}};
      level_r <= {LW{1'b0}};
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      ovf_r   <= 1'b0;
    end else begin
      if (push_s) wptr_r <= wptr_r + AW'(1);
      if (pop_s)  rptr_r <= rptr_r + AW'(1);
      level_r <= level_s;
      full_r  <= (level_s == DEPTH_L);
      empty_r <= (level_s == {LW{1'b0}});
      if (wr_en && full_r) ovf_r <= 1'b1;
      else if (clr_ovf)    ovf_r <= 1'b0;
    end
  end

  // TX state register and registered serial line
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      bcnt_r   <= {BCW{1'b0}};
      bitcnt_r <= {BTW{1'b0}};
      shreg_r  <= {DATA_BITS{1'b0}};
      busy_r   <= 1'b0;
      tx_r     <= 1'b1;
    end else begin
      state_r  <= state_s;
      bcnt_r   <= bcnt_s;
      bitcnt_r <= bitcnt_s;
      shreg_r  <= shreg_s;
      busy_r   <= (state_s != IDLE);
      tx_r     <= tx_s;
    end
  end

  // TX next-state, pop request and next line level
  always_comb begin
    state_s  = state_r;
    bcnt_s   = bcnt_r;
    bitcnt_s = bitcnt_r;
    shreg_s  = shreg_r;
    pop_s    = 1'b0;
    tx_s     = 1'b1;
    case (state_r)
      IDLE: begin
        if (!empty_r) begin
          pop_s    = 1'b1;
          shreg_s  = mem_r[rptr_r];
          bcnt_s   = {BCW{1'b0}};
          bitcnt_s = {BTW{1'b0}};
          state_s  = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (bcnt_r == BIT_LAST) begin
          bcnt_s  = {BCW{1'b0}};
          state_s = DATA;
        end else begin
          bcnt_s = bcnt_r + BCW'(1);
        end
      end
      DATA: begin
        if (bcnt_r == BIT_LAST) begin
          bcnt_s  = {BCW{1'b0}};
          shreg_s = shreg_r >> 1;
          if (bitcnt_r == DATA_LAST) begin
            state_s = STOP;
          end else begin
            bitcnt_s = bitcnt_r + BTW'(1);
          end
        end else begin
          bcnt_s = bcnt_r + BCW'(1);
        end
      end
      STOP: begin
        if (bcnt_r == STOP_LAST) begin
          bcnt_s = {BCW{1'b0}};
          if (!empty_r) begin
            // back-to-back frame: no idle bit between stop and next start
            pop_s    = 1'b1;
            shreg_s  = mem_r[rptr_r];
            bitcnt_s = {BTW{1'b0}};
            state_s  = START;
          end else begin
            state_s = IDLE;
          end
        end else begin
          bcnt_s = bcnt_r + BCW'(1);
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    case (state_s)
      START:   tx_s = 1'b0;
      DATA:    tx_s = shreg_s[0];
      default: tx_s = 1'b1;
    endcase
  end

  assign full     = full_r;
  assign empty    = empty_r;
  assign level    = level_r;
  assign busy     = busy_r;
  assign overflow = ovf_r;
  assign uart_tx  = tx_r;

endmodule
